// File: rtl/out_port_fifo_bank_pkg.sv
// out_port_fifo_bank_pkg: shared defaults, channel names and sizing helper for the output FIFO bank
package out_port_fifo_bank_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;
    localparam int DEF_DEPTH = 4;
    typedef enum logic [1:0] {CH_0, CH_1, CH_2, CH_3} chan_e;
    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/out_port_fifo_bank_if.sv
// out_port_fifo_bank_if: CPU write port and per-channel consumer handshake; ovf present under OUT_PORT_OVF_EN
interface out_port_fifo_bank_if
    import out_port_fifo_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int SELW  = $clog2(DEF_NCH)
);
    logic                 we;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     wd;
    logic                 wr_ready;
    logic [NCH*WIDTH-1:0] out_data;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;
    logic [NCH-1:0]       full;
`ifdef OUT_PORT_OVF_EN
    logic [NCH-1:0]       ovf;
    modport master (output we, sel, wd, out_ready, input wr_ready, out_data, out_valid, full, ovf);
    modport slave  (input we, sel, wd, out_ready, output wr_ready, out_data, out_valid, full, ovf);
`else
    modport master (output we, sel, wd, out_ready, input wr_ready, out_data, out_valid, full);
    modport slave  (input we, sel, wd, out_ready, output wr_ready, out_data, out_valid, full);
`endif
endinterface

// File: rtl/out_port_fifo_bank_chan.sv
// out_chan_fifo: one first-word-fall-through channel FIFO; sticky overflow flag under OUT_PORT_OVF_EN
module out_chan_fifo
    import out_port_fifo_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop_rdy,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
`ifdef OUT_PORT_OVF_EN
    output logic             o_ovf,
`endif
    output logic             o_full
);
    localparam int AW = ptr_bits(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // i_push is the raw request; acceptance uses the start-of-cycle full flag
    assign w_push  = i_push && !o_full;
    assign w_pop   = o_valid && i_pop_rdy;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_valid = r_count != '0;
    assign o_dout  = o_valid ? r_mem[r_rptr] : '0;

    // pointers and occupancy; reset discards queued data without a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // storage is deliberately left unreset; the count gates everything visible
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

`ifdef OUT_PORT_OVF_EN
    logic r_ovf;
    assign o_ovf = r_ovf;

    // sticky flag on a dropped write; an accepted zero word acknowledges it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ovf <= 1'b0;
        else if (i_push && o_full) r_ovf <= 1'b1;
        else if (w_push && i_din == '0) r_ovf <= 1'b0;
    end
`endif
endmodule

// File: rtl/out_port_fifo_bank.sv
// out_port_fifo_bank: NCH output channels, each a DEPTH-entry FIFO fed by the CPU write port (OUT_PORT_OVF_EN adds ovf)
module out_port_fifo_bank
    import out_port_fifo_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SELW  = 2
) (
    input logic                clk,
    input logic                reset,
    out_port_fifo_bank_if.slave bus
);
    localparam logic [SELW:0] NCH_LIM = (SELW + 1)'(NCH);

    logic [NCH-1:0]       w_push_req;
    logic [NCH-1:0]       w_valid;
    logic [NCH-1:0]       w_full;
    logic [NCH*WIDTH-1:0] w_data;
`ifdef OUT_PORT_OVF_EN
    logic [NCH-1:0]       w_ovf;
    assign bus.ovf = w_ovf;
`endif

    // one-hot write request; out-of-range selects shift out to nothing
    assign w_push_req    = bus.we ? ({{(NCH-1){1'b0}}, 1'b1} << bus.sel) : '0;
    assign bus.wr_ready  = ({1'b0, bus.sel} < NCH_LIM) && !w_full[bus.sel];
    assign bus.out_valid = w_valid;
    assign bus.full      = w_full;
    assign bus.out_data  = w_data;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        out_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan (
            .clk      (clk),
            .reset    (reset),
            .i_push   (w_push_req[g]),
            .i_din    (bus.wd),
            .i_pop_rdy(bus.out_ready[g]),
            .o_dout   (w_data[g*WIDTH +: WIDTH]),
            .o_valid  (w_valid[g]),
`ifdef OUT_PORT_OVF_EN
            .o_ovf    (w_ovf[g]),
`endif
            .o_full   (w_full[g])
        );
    end
endmodule

// File: tb/tb_out_port_fifo_bank.sv
// tb_out_port_fifo_bank: directed table vectors plus hand sequences for the output FIFO bank
`timescale 1ns/1ps
module tb_out_port_fifo_bank;
    import out_port_fifo_bank_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    out_port_fifo_bank_if #(.WIDTH(8), .NCH(4), .SELW(2)) bus ();

    out_port_fifo_bank #(.WIDTH(8), .NCH(4), .DEPTH(4), .SELW(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [7:0]  wd;
        logic [3:0]  ordy;
        logic [3:0]  e_valid;
        logic [3:0]  e_full;
        logic [31:0] e_data;
        logic        e_wrr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sel, input logic [7:0] wd, input logic [3:0] ordy);
        bus.we        = we;
        bus.sel       = sel;
        bus.wd        = wd;
        bus.out_ready = ordy;
    endtask

    task automatic cyc(input logic we, input logic [1:0] sel, input logic [7:0] wd, input logic [3:0] ordy);
        drive(we, sel, wd, ordy);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 8'h00, 4'h0);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'h0);
        // T1: async reset, no clock edge yet
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", {28'h0, bus.out_valid}, 32'h0);
        chk("rst_full", {28'h0, bus.full}, 32'h0);
        chk("rst_data", bus.out_data, 32'h0);
`ifdef OUT_PORT_OVF_EN
        chk("rst_ovf", {28'h0, bus.ovf}, 32'h0);
`endif
        #1 reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            #1;
            chk($sformatf("rst_wrr%0d", s), {31'h0, bus.wr_ready}, 32'h1);
        end
        @(posedge clk);
        #1;

        // T2 and T3: expected values are the outputs seen before each row's clock edge
        vecs[0]  = '{1'b1, CH_2, 8'hA5, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 1'b1};
        vecs[1]  = '{1'b0, CH_0, 8'h00, 4'h4, 4'h4, 4'h0, 32'h00A5_0000, 1'b1};
        vecs[2]  = '{1'b0, CH_0, 8'h00, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b1, CH_1, 8'h11, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b1, CH_1, 8'h22, 4'h0, 4'h2, 4'h0, 32'h0000_1100, 1'b1};
        vecs[5]  = '{1'b1, CH_1, 8'h33, 4'h0, 4'h2, 4'h0, 32'h0000_1100, 1'b1};
        vecs[6]  = '{1'b1, CH_1, 8'h44, 4'h0, 4'h2, 4'h0, 32'h0000_1100, 1'b1};
        vecs[7]  = '{1'b1, CH_1, 8'h55, 4'h0, 4'h2, 4'h2, 32'h0000_1100, 1'b0};
        vecs[8]  = '{1'b0, CH_0, 8'h00, 4'h2, 4'h2, 4'h2, 32'h0000_1100, 1'b1};
        vecs[9]  = '{1'b0, CH_1, 8'h00, 4'h2, 4'h2, 4'h0, 32'h0000_2200, 1'b1};
        vecs[10] = '{1'b0, CH_1, 8'h00, 4'h2, 4'h2, 4'h0, 32'h0000_3300, 1'b1};
        vecs[11] = '{1'b0, CH_1, 8'h00, 4'h2, 4'h2, 4'h0, 32'h0000_4400, 1'b1};
        vecs[12] = '{1'b0, CH_1, 8'h00, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 1'b1};
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].we, vecs[i].sel, vecs[i].wd, vecs[i].ordy);
            #1;
            chk($sformatf("vec%0d_valid", i), {28'h0, bus.out_valid}, {28'h0, vecs[i].e_valid});
            chk($sformatf("vec%0d_full", i), {28'h0, bus.full}, {28'h0, vecs[i].e_full});
            chk($sformatf("vec%0d_data", i), bus.out_data, vecs[i].e_data);
            chk($sformatf("vec%0d_wrr", i), {31'h0, bus.wr_ready}, {31'h0, vecs[i].e_wrr});
            @(posedge clk);
            #1;
        end
        drive(1'b0, 2'd0, 8'h00, 4'h0);
`ifdef OUT_PORT_OVF_EN
        #1;
        chk("ovf_set", {28'h0, bus.ovf}, 32'h2);
        cyc(1'b1, CH_1, 8'h00, 4'h0);
        chk("ovf_clr", {28'h0, bus.ovf}, 32'h0);
        cyc(1'b0, CH_1, 8'h00, 4'h2);
`endif

        // T4: push+pop on a two-entry channel keeps depth and order
        cyc(1'b1, CH_0, 8'h01, 4'h0);
        cyc(1'b1, CH_0, 8'h02, 4'h0);
        cyc(1'b1, CH_0, 8'h03, 4'h1);
        chk("sim_valid", {31'h0, bus.out_valid[0]}, 32'h1);
        chk("sim_head", {24'h0, bus.out_data[7:0]}, 32'h02);
        cyc(1'b0, CH_0, 8'h00, 4'h1);
        chk("sim_head2", {24'h0, bus.out_data[7:0]}, 32'h03);
        cyc(1'b0, CH_0, 8'h00, 4'h1);
        chk("sim_empty", {31'h0, bus.out_valid[0]}, 32'h0);
        // full channel: push rejected, pop proceeds
        cyc(1'b1, CH_0, 8'h0A, 4'h0);
        cyc(1'b1, CH_0, 8'h0B, 4'h0);
        cyc(1'b1, CH_0, 8'h0C, 4'h0);
        cyc(1'b1, CH_0, 8'h0D, 4'h0);
        chk("f_full", {31'h0, bus.full[0]}, 32'h1);
        drive(1'b1, CH_0, 8'hEE, 4'h1);
        #1;
        chk("f_wrr", {31'h0, bus.wr_ready}, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 8'h00, 4'h0);
        #1;
        chk("f_notfull", {31'h0, bus.full[0]}, 32'h0);
        chk("f_head", {24'h0, bus.out_data[7:0]}, 32'h0B);
        cyc(1'b0, CH_0, 8'h00, 4'h1);
        chk("f_head2", {24'h0, bus.out_data[7:0]}, 32'h0C);
        cyc(1'b0, CH_0, 8'h00, 4'h1);
        chk("f_head3", {24'h0, bus.out_data[7:0]}, 32'h0D);
        cyc(1'b0, CH_0, 8'h00, 4'h1);
        chk("f_empty", {31'h0, bus.out_valid[0]}, 32'h0);

        // T5: pointer wrap on ch3
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, CH_3, 8'(i), 4'h0);
            chk($sformatf("wrap%0d_data", i), {24'h0, bus.out_data[31:24]}, i);
            cyc(1'b0, CH_3, 8'h00, 4'h8);
            chk($sformatf("wrap%0d_empty", i), {31'h0, bus.out_valid[3]}, 32'h0);
        end

        // T6: reset between clock edges
        cyc(1'b1, CH_0, 8'h31, 4'h0);
        cyc(1'b1, CH_2, 8'h61, 4'h0);
        cyc(1'b1, CH_0, 8'h32, 4'h0);
        cyc(1'b1, CH_2, 8'h62, 4'h0);
        cyc(1'b1, CH_0, 8'h33, 4'h0);
        cyc(1'b1, CH_2, 8'h63, 4'h0);
        chk("mid_valid", {28'h0, bus.out_valid}, 32'h5);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {28'h0, bus.out_valid}, 32'h0);
        chk("mid_rst_data", bus.out_data, 32'h0);
        reset = 1'b0;
        cyc(1'b1, CH_2, 8'h77, 4'h0);
        chk("post_valid", {28'h0, bus.out_valid}, 32'h4);
        chk("post_data", bus.out_data, 32'h0077_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
